// File: rtl/kamacore_regfile.sv
// kamacore_regfile
//   Integer register file at the consumer end of the writeback path. The WB stage
//   can commit one write per cycle, and decode reads through two ports (rs1, rs2).
//   Register x0 always reads as zero. When WRITE_BYPASS is set, a read of the
//   register being written in the same cycle returns the incoming write data. This
//   lets WB and decode share a cycle without a structural hazard.
//
// Parameters
//   CPU_WIDTH       data width of each register
//   REG_ADDR_WIDTH  register address width; register count = 2**REG_ADDR_WIDTH
//   READ_REG        0: combinational read (0-cycle); 1: registered read (1-cycle)
//   WRITE_BYPASS    1: same-cycle write data is forwarded to a matching read
//
// Ports
//   clk                in   core clock, rising edge
//   rst                in   asynchronous, active-low reset
//   writeback_rd_we    in   write enable from WB
//   writeback_rd_a     in   destination register address
//   writeback_rd_data  in   destination write data
//   rd_en              in   read enable (only used when READ_REG=1)
//   rs1_a, rs2_a       in   read port addresses
//   rs1_data, rs2_data out  read port data
//   wr_count           out  number of committed non-x0 writes (wraps)
module kamacore_regfile #(
  parameter int CPU_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter bit READ_REG       = 1'b0,
  parameter bit WRITE_BYPASS   = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      writeback_rd_we,
  input  logic [REG_ADDR_WIDTH-1:0] writeback_rd_a,
  input  logic [CPU_WIDTH-1:0]      writeback_rd_data,
  input  logic                      rd_en,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_a,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_a,
  output logic [CPU_WIDTH-1:0]      rs1_data,
  output logic [CPU_WIDTH-1:0]      rs2_data,
  output logic [31:0]               wr_count
);

  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

  logic [CPU_WIDTH-1:0] regs [NUM_REGS];
  logic [31:0]          wr_count_q;
  logic                 commit;
  logic [CPU_WIDTH-1:0] rs1_next;
  logic [CPU_WIDTH-1:0] rs2_next;

  // Writes to x0 are dropped here, so regs[0] is never loaded and stays at its
  // reset value. Reads of x0 are still forced to zero below and never depend on it.
  assign commit = writeback_rd_we && (writeback_rd_a != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      regs[writeback_rd_a] <= writeback_rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_count_q <= '0;
    end else if (commit) begin
      wr_count_q <= wr_count_q + 32'd1;
    end
  end

  assign wr_count = wr_count_q;

  // Read value seen by decode in this cycle, with bypass included. The registered
  // read mode samples this same expression, so a write and a read on the same edge
  // agree.
  always_comb begin
    rs1_next = '0;
    if (rs1_a != '0) begin
      if (WRITE_BYPASS && writeback_rd_we && (writeback_rd_a == rs1_a)) begin
        rs1_next = writeback_rd_data;
      end else begin
        rs1_next = regs[rs1_a];
      end
    end
  end

  always_comb begin
    rs2_next = '0;
    if (rs2_a != '0) begin
      if (WRITE_BYPASS && writeback_rd_we && (writeback_rd_a == rs2_a)) begin
        rs2_next = writeback_rd_data;
      end else begin
        rs2_next = regs[rs2_a];
      end
    end
  end

  generate
    if (READ_REG) begin : g_read_reg
      logic [CPU_WIDTH-1:0] rs1_q;
      logic [CPU_WIDTH-1:0] rs2_q;

      // When rd_en is low, the previous data is held so decode can stall.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rs1_q <= '0;
          rs2_q <= '0;
        end else if (rd_en) begin
          rs1_q <= rs1_next;
          rs2_q <= rs2_next;
        end
      end

      assign rs1_data = rs1_q;
      assign rs2_data = rs2_q;
    end else begin : g_read_comb
      logic unused_rd_en;
      assign unused_rd_en = rd_en;
      assign rs1_data     = rs1_next;
      assign rs2_data     = rs2_next;
    end
  endgenerate

endmodule
